rv_writeback: RTL and testbench
===============================

# rv_writeback

Write-back unit driving the single write port of the core's register file. Merges in-order ALU results with load responses from the data-memory interface, buffers ALU results that lose arbitration, tracks destination registers of outstanding loads, and gives decode a stall indication plus forwarded operands. It compensates for the register file's one-cycle registered read, whose array read does not see a write made in the same cycle.

## Interface
- `ALU_DEPTH`, 2: ALU result FIFO entries (power of two, ≥2).
- `LD_DEPTH`, 2: maximum outstanding loads (power of two, ≥1).

- `i_clk` in 1: clock; all state on rising edge.
- `i_reset_n` in 1: asynchronous active-low reset.
- `i_alu_valid` in 1: ALU result offered.
- `i_alu_rd` in 5: ALU destination register.
- `i_alu_data` in 32: ALU result.
- `o_alu_ready` out 1: FIFO can accept; a transfer occurs when valid and ready are both high.
- `i_ld_issue` in 1: load issued this cycle; qualified by `o_ld_issue_ready`.
- `i_ld_rd` in 5: destination register of the issued load.
- `o_ld_issue_ready` out 1: load queue not full.
- `i_ld_rvalid` in 1: load data returns, in issue order; there is no back-pressure.
- `i_ld_rdata` in 32: load data, already extended.
- `i_dec_rs1`, `i_dec_rs2`, `i_dec_rd` in 5 each: registers of the instruction in decode.
- `o_stall` out 1: decode must hold.
- `o_fwd1_valid`, `o_fwd2_valid` out 1: forwarded operand overrides register-file data.
- `o_fwd1_data`, `o_fwd2_data` out 32: forwarded operands.
- `o_write` out 1, `o_rd` out 5, `o_data` out 32: register-file write port.

## Operation
- **Output stage.** `o_write`, `o_rd` and `o_data` are registered. Reset values: `o_write` = 0, `o_rd` = 0, `o_data` = 0.
- **Arbitration.** Each cycle at most one result enters the output stage. Priority:
  - 1. Load response.
  - 2. ALU FIFO head.
  - 3. Incoming ALU result when the FIFO is empty (bypass).
- **ALU FIFO.**
  - An incoming ALU result that does not win is pushed.
  - `o_alu_ready` = FIFO count < `ALU_DEPTH`, combinational from the count.
  - When the FIFO is full, a pop in the same cycle does not raise ready.
- **Load queue.**
  - Holds the rd of each outstanding load.
  - Pushed on `i_ld_issue && o_ld_issue_ready`; popped on `i_ld_rvalid`.
  - An issue and a response in the same cycle are legal at any fill level except full, where the issue is not accepted.
  - `i_ld_rvalid` with an empty queue is a protocol violation: the response is ignored and a simulation assertion fires.
- **Destination x0.** A winning result with rd = 0 is consumed, but `o_write` stays 0.
- **Stall.** `o_stall` = 1 when any nonzero `i_dec_rs1`, `i_dec_rs2` or `i_dec_rd` equals an rd in the load queue. This covers RAW and WAW.
- **Forwarding, per operand.**
  - Candidates: ALU FIFO entries, the output stage while `o_write` = 1, and the previous output-stage write, held one extra cycle for the registered read.
  - The youngest matching candidate wins. rs = 0 never forwards.
- **Queue order.** Both queues use pointer wrap-around modulo depth plus a count.
- **Reset mid-operation.** Reset empties both queues and discards pending results. Responses arriving after reset are treated as a violation.

## Timing
- A load response in cycle N produces `o_write` in N+1.
- An ALU result accepted in cycle N with the FIFO empty and no load response produces `o_write` in N+1.
- If a load response arrives in the same cycle N, the ALU result is written in N+2.
- Back-to-back load responses starve the FIFO, and ALU throughput drops to 0. Ready falls once `ALU_DEPTH` results are queued.
- `o_stall`, `o_fwd*` and the ready outputs are combinational from state and inputs. No combinational path exists from `i_ld_rvalid` to `o_ld_issue_ready`.

## Configuration
- `RV_WB_FWD_EN` defined: forwarding as specified above.
- `RV_WB_FWD_EN` undefined:
  - `o_fwd*_valid` and `o_fwd*_data` are tied to 0.
  - `o_stall` additionally asserts on any nonzero rs match in the ALU FIFO, the output stage or the held previous write.

## Structure
- Shared package `rv_pkg`:
  - Typedef `reg_idx_t` (logic[4:0]).
  - Struct `wb_entry_t` {rd, data}.
  - Constant `REG_ZERO`.
- One sub-module, `rv_wb_fifo`: parameterised circular FIFO of `wb_entry_t` with count and a flattened entry view for forward matching. It is instantiated for the ALU FIFO; the load queue uses it with data unused.

## Test plan
- ALU rd=5 data=0x1234 with FIFO empty → next cycle `o_write`=1, `o_rd`=5, `o_data`=0x1234.
- Issue load rd=7. Decode rs1=7 → `o_stall`=1. Response 0xCAFE → next cycle write x7=0xCAFE and `o_stall`=0.
- Load response and ALU rd=3 in the same cycle → x-load written first, x3 one cycle later. Four consecutive responses with ALU valid → ready drops after 2 accepts.
- ALU rd=0 data=0xFFFF → result consumed, `o_write` stays 0. Decode rs1=0 → no forward.
- ALU rd=9 then rd=9 queued, decode rs2=9 → `o_fwd2_data` equals the younger value. With `RV_WB_FWD_EN` undefined, `o_stall`=1 instead.
- Two loads outstanding with `LD_DEPTH`=2 → `o_ld_issue_ready`=0. Assert reset mid-flight → queues empty, all outputs 0, ready=1 after release.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared types for the write-back slice: register index, write-back entry,
// arbitration source encoding and a nonzero-register match helper.
package rv_pkg;

  typedef logic [4:0] reg_idx_t;

  typedef struct packed {
    reg_idx_t    rd;
    logic [31:0] data;
  } wb_entry_t;

  localparam reg_idx_t REG_ZERO = 5'd0;

  // Which producer feeds the output stage this cycle.
  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_LOAD,
    SRC_FIFO,
    SRC_BYPASS
  } wb_src_e;

  // True when a nonzero register index matches a destination.
  function automatic logic rd_hit(input reg_idx_t rs, input reg_idx_t rd);
    return (rs != REG_ZERO) && (rs == rd);
  endfunction

endpackage

// File: rtl/rv_wb_fifo.sv
// Circular FIFO of write-back entries with wrap-around pointers plus a count.
// Also exposes every slot in age order (index 0 = oldest) with a valid mask,
// so the owner can search for register matches.
module rv_wb_fifo
  import rv_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    push_i,
  input  wb_entry_t               push_entry_i,
  input  logic                    pop_i,
  output wb_entry_t               head_o,
  output logic                    full_o,
  output logic                    empty_o,
  output wb_entry_t [DEPTH-1:0]   entries_o,
  output logic      [DEPTH-1:0]   valid_o
);

  localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW    = $clog2(DEPTH + 1);
  localparam int unsigned SLOTS = 1 << PW;

  wb_entry_t         mem_q [SLOTS];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              push_ok, pop_ok;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  // Next pointer and occupancy values.
  always_comb begin
    wr_ptr_d = push_ok ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop_ok  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
  end

  // Pointer and count registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are qualified by the count, so no reset needed.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_entry_i;
    end
  end

  // Age-ordered view of the occupied slots.
  always_comb begin
    logic [PW-1:0] idx;
    idx       = '0;
    entries_o = '0;
    valid_o   = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx          = ptr_inc_n(rd_ptr_q, k);
      entries_o[k] = mem_q[idx];
      valid_o[k]   = (CW'(k) < count_q);
    end
  end

  function automatic logic [PW-1:0] ptr_inc_n(input logic [PW-1:0] p, input int unsigned n);
    logic [PW-1:0] r;
    r = p;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (i < n) r = ptr_inc(r);
    end
    return r;
  endfunction

endmodule

// File: rtl/rv_writeback.sv
// Write-back unit for the register-file write port. Arbitrates load responses
// over buffered and incoming ALU results, tracks outstanding load destinations
// for stalling, and forwards operands around the registered register-file read.
// Optional feature macro: RV_WB_FWD_EN (forwarding; when undefined, operand
// hazards on pending writes stall decode instead).
module rv_writeback
  import rv_pkg::*;
#(
  parameter int unsigned ALU_DEPTH = 2,
  parameter int unsigned LD_DEPTH  = 2
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_alu_valid,
  input  logic [4:0]  i_alu_rd,
  input  logic [31:0] i_alu_data,
  output logic        o_alu_ready,
  input  logic        i_ld_issue,
  input  logic [4:0]  i_ld_rd,
  output logic        o_ld_issue_ready,
  input  logic        i_ld_rvalid,
  input  logic [31:0] i_ld_rdata,
  input  logic [4:0]  i_dec_rs1,
  input  logic [4:0]  i_dec_rs2,
  input  logic [4:0]  i_dec_rd,
  output logic        o_stall,
  output logic        o_fwd1_valid,
  output logic        o_fwd2_valid,
  output logic [31:0] o_fwd1_data,
  output logic [31:0] o_fwd2_data,
  output logic        o_write,
  output logic [4:0]  o_rd,
  output logic [31:0] o_data
);

  wb_entry_t                  alu_head, ld_head;
  logic                       alu_full, alu_empty, ld_full, ld_empty;
  wb_entry_t [ALU_DEPTH-1:0]  alu_entries;
  logic      [ALU_DEPTH-1:0]  alu_valid;
  wb_entry_t [LD_DEPTH-1:0]   ld_entries;
  logic      [LD_DEPTH-1:0]   ld_valid;

  wb_src_e     src;
  wb_entry_t   win;
  logic        ld_resp, alu_acc, alu_push, alu_pop, ld_push;
  logic        write_d;

  logic        write_q, prev_write_q;
  reg_idx_t    rd_q, prev_rd_q;
  logic [31:0] data_q, prev_data_q;

  logic        ld_hit;
  logic [32:0] pick1, pick2;
  logic        ld_unused;

  assign ld_resp  = i_ld_rvalid && !ld_empty;
  assign alu_acc  = i_alu_valid && !alu_full;
  assign alu_push = alu_acc && (src != SRC_BYPASS);
  assign alu_pop  = (src == SRC_FIFO);
  assign ld_push  = i_ld_issue && !ld_full;

  rv_wb_fifo #(.DEPTH(ALU_DEPTH)) u_alu_fifo (
    .clk_i        (i_clk),
    .rst_ni       (i_reset_n),
    .push_i       (alu_push),
    .push_entry_i ('{rd: i_alu_rd, data: i_alu_data}),
    .pop_i        (alu_pop),
    .head_o       (alu_head),
    .full_o       (alu_full),
    .empty_o      (alu_empty),
    .entries_o    (alu_entries),
    .valid_o      (alu_valid)
  );

  rv_wb_fifo #(.DEPTH(LD_DEPTH)) u_ld_queue (
    .clk_i        (i_clk),
    .rst_ni       (i_reset_n),
    .push_i       (ld_push),
    .push_entry_i ('{rd: i_ld_rd, data: '0}),
    .pop_i        (ld_resp),
    .head_o       (ld_head),
    .full_o       (ld_full),
    .empty_o      (ld_empty),
    .entries_o    (ld_entries),
    .valid_o      (ld_valid)
  );

  // The load queue only carries destinations; its data field is never read.
  assign ld_unused = ^{ld_head, ld_entries};

  // Pick the single result entering the output stage this cycle.
  always_comb begin
    src = SRC_NONE;
    win = '0;
    if (ld_resp) begin
      src = SRC_LOAD;
      win = '{rd: ld_head.rd, data: i_ld_rdata};
    end else if (!alu_empty) begin
      src = SRC_FIFO;
      win = alu_head;
    end else if (alu_acc) begin
      src = SRC_BYPASS;
      win = '{rd: i_alu_rd, data: i_alu_data};
    end
    write_d = (src != SRC_NONE) && (win.rd != REG_ZERO);
  end

  // Output stage plus the previous write held for the registered read.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      write_q      <= 1'b0;
      rd_q         <= '0;
      data_q       <= '0;
      prev_write_q <= 1'b0;
      prev_rd_q    <= '0;
      prev_data_q  <= '0;
    end else begin
      write_q      <= write_d;
      if (write_d) begin
        rd_q   <= win.rd;
        data_q <= win.data;
      end
      prev_write_q <= write_q;
      prev_rd_q    <= rd_q;
      prev_data_q  <= data_q;
    end
  end

  assign o_write          = write_q;
  assign o_rd             = rd_q;
  assign o_data           = data_q;
  assign o_alu_ready      = !alu_full;
  assign o_ld_issue_ready = !ld_full;

  // Youngest pending write to rs: held write, then output stage, then FIFO
  // oldest to youngest, each later match overriding the earlier one.
  function automatic logic [32:0] fwd_pick(input reg_idx_t rs);
    logic [32:0] r;
    r = '0;
    if (prev_write_q && rd_hit(rs, prev_rd_q)) r = {1'b1, prev_data_q};
    if (write_q && rd_hit(rs, rd_q))           r = {1'b1, data_q};
    for (int unsigned k = 0; k < ALU_DEPTH; k++) begin
      if (alu_valid[k] && rd_hit(rs, alu_entries[k].rd)) r = {1'b1, alu_entries[k].data};
    end
    return r;
  endfunction

  // Decode hazard against outstanding load destinations (RAW and WAW).
  always_comb begin
    ld_hit = 1'b0;
    for (int unsigned k = 0; k < LD_DEPTH; k++) begin
      if (ld_valid[k] && (rd_hit(i_dec_rs1, ld_entries[k].rd) ||
                          rd_hit(i_dec_rs2, ld_entries[k].rd) ||
                          rd_hit(i_dec_rd,  ld_entries[k].rd))) begin
        ld_hit = 1'b1;
      end
    end
  end

  // Operand match search for both decode sources.
  always_comb begin
    pick1 = fwd_pick(i_dec_rs1);
    pick2 = fwd_pick(i_dec_rs2);
  end

`ifdef RV_WB_FWD_EN
  assign o_stall      = ld_hit;
  assign o_fwd1_valid = pick1[32];
  assign o_fwd1_data  = pick1[31:0];
  assign o_fwd2_valid = pick2[32];
  assign o_fwd2_data  = pick2[31:0];
`else
  logic fwd_unused;
  assign fwd_unused   = ^{pick1[31:0], pick2[31:0]};
  assign o_stall      = ld_hit || pick1[32] || pick2[32];
  assign o_fwd1_valid = 1'b0;
  assign o_fwd1_data  = '0;
  assign o_fwd2_valid = 1'b0;
  assign o_fwd2_data  = '0;
`endif

  // A load response with nothing outstanding is dropped and flagged.
  a_ld_rvalid_empty: assert property (@(posedge i_clk) disable iff (!i_reset_n)
    !(i_ld_rvalid && ld_empty));

endmodule

// File: tb/tb_rv_writeback.sv
module tb_rv_writeback;

`ifdef RV_WB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        i_clk = 1'b0;
  logic        i_reset_n;
  logic        i_alu_valid;
  logic [4:0]  i_alu_rd;
  logic [31:0] i_alu_data;
  logic        o_alu_ready;
  logic        i_ld_issue;
  logic [4:0]  i_ld_rd;
  logic        o_ld_issue_ready;
  logic        i_ld_rvalid;
  logic [31:0] i_ld_rdata;
  logic [4:0]  i_dec_rs1, i_dec_rs2, i_dec_rd;
  logic        o_stall;
  logic        o_fwd1_valid, o_fwd2_valid;
  logic [31:0] o_fwd1_data, o_fwd2_data;
  logic        o_write;
  logic [4:0]  o_rd;
  logic [31:0] o_data;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 i_clk = ~i_clk;

  rv_writeback #(.ALU_DEPTH(2), .LD_DEPTH(2)) dut (
    .i_clk            (i_clk),
    .i_reset_n        (i_reset_n),
    .i_alu_valid      (i_alu_valid),
    .i_alu_rd         (i_alu_rd),
    .i_alu_data       (i_alu_data),
    .o_alu_ready      (o_alu_ready),
    .i_ld_issue       (i_ld_issue),
    .i_ld_rd          (i_ld_rd),
    .o_ld_issue_ready (o_ld_issue_ready),
    .i_ld_rvalid      (i_ld_rvalid),
    .i_ld_rdata       (i_ld_rdata),
    .i_dec_rs1        (i_dec_rs1),
    .i_dec_rs2        (i_dec_rs2),
    .i_dec_rd         (i_dec_rd),
    .o_stall          (o_stall),
    .o_fwd1_valid     (o_fwd1_valid),
    .o_fwd2_valid     (o_fwd2_valid),
    .o_fwd1_data      (o_fwd1_data),
    .o_fwd2_data      (o_fwd2_data),
    .o_write          (o_write),
    .o_rd             (o_rd),
    .o_data           (o_data)
  );

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    i_alu_valid = 1'b0; i_alu_rd = '0; i_alu_data = '0;
    i_ld_issue  = 1'b0; i_ld_rd  = '0;
    i_ld_rvalid = 1'b0; i_ld_rdata = '0;
    i_dec_rs1 = '0; i_dec_rs2 = '0; i_dec_rd = '0;
  endtask

  initial begin
    idle_inputs();
    i_reset_n = 1'b0;
    tick(); tick();
    chk1 ("rst_write",    o_write, 1'b0);
    chk32("rst_rd",       32'(o_rd), 32'd0);
    chk32("rst_data",     o_data, 32'd0);
    chk1 ("rst_alu_rdy",  o_alu_ready, 1'b1);
    chk1 ("rst_ld_rdy",   o_ld_issue_ready, 1'b1);
    chk1 ("rst_stall",    o_stall, 1'b0);
    i_reset_n = 1'b1;
    tick();

    // ALU bypass: accepted with empty FIFO, written next cycle.
    i_alu_valid = 1'b1; i_alu_rd = 5'd5; i_alu_data = 32'h1234;
    tick();
    i_alu_valid = 1'b0;
    chk1 ("byp_write", o_write, 1'b1);
    chk32("byp_rd",    32'(o_rd), 32'd5);
    chk32("byp_data",  o_data, 32'h1234);

    // Load rd=7 outstanding stalls a reader of x7.
    i_ld_issue = 1'b1; i_ld_rd = 5'd7;
    tick();
    i_ld_issue = 1'b0; i_dec_rs1 = 5'd7;
    #1;
    chk1("ld_stall",      o_stall, 1'b1);
    chk1("ld_nowrite",    o_write, 1'b0);
    i_ld_rvalid = 1'b1; i_ld_rdata = 32'hCAFE;
    tick();
    i_ld_rvalid = 1'b0;
    chk1 ("ld_write",     o_write, 1'b1);
    chk32("ld_rd",        32'(o_rd), 32'd7);
    chk32("ld_data",      o_data, 32'hCAFE);
    chk1 ("ld_out_stall", o_stall, !FWD);
    chk1 ("ld_out_fv",    o_fwd1_valid, FWD);
    chk32("ld_out_fd",    o_fwd1_data, FWD ? 32'hCAFE : 32'h0);
    tick();
    chk1 ("held_stall",   o_stall, !FWD);
    chk1 ("held_fv",      o_fwd1_valid, FWD);
    chk32("held_fd",      o_fwd1_data, FWD ? 32'hCAFE : 32'h0);
    tick();
    chk1 ("aged_stall",   o_stall, 1'b0);
    chk1 ("aged_fv",      o_fwd1_valid, 1'b0);
    i_dec_rs1 = '0;

    // Load response and ALU rd=3 together: load first, x3 one cycle later.
    i_ld_issue = 1'b1; i_ld_rd = 5'd8;
    tick();
    i_ld_issue = 1'b0;
    i_ld_rvalid = 1'b1; i_ld_rdata = 32'h1111;
    i_alu_valid = 1'b1; i_alu_rd = 5'd3; i_alu_data = 32'h3333;
    tick();
    i_ld_rvalid = 1'b0; i_alu_valid = 1'b0; i_dec_rs2 = 5'd3;
    #1;
    chk32("coll_rd1",     32'(o_rd), 32'd8);
    chk32("coll_data1",   o_data, 32'h1111);
    chk1 ("coll_stall",   o_stall, !FWD);
    chk32("coll_fwd2",    o_fwd2_data, FWD ? 32'h3333 : 32'h0);
    tick();
    chk1 ("coll_write2",  o_write, 1'b1);
    chk32("coll_rd2",     32'(o_rd), 32'd3);
    chk32("coll_data2",   o_data, 32'h3333);
    i_dec_rs2 = '0;

    // Four back-to-back responses with ALU offered each cycle.
    i_ld_issue = 1'b1; i_ld_rd = 5'd10;
    tick();
    i_ld_rvalid = 1'b1; i_ld_rdata = 32'hD10; i_ld_rd = 5'd12;
    i_alu_valid = 1'b1; i_alu_rd = 5'd20; i_alu_data = 32'hA0;
    #1;
    chk1("b2b_rdy1", o_alu_ready, 1'b1);
    tick();
    chk32("b2b_rd1", 32'(o_rd), 32'd10);
    i_ld_rdata = 32'hD12; i_ld_rd = 5'd13; i_alu_rd = 5'd21; i_alu_data = 32'hA1;
    #1;
    chk1("b2b_rdy2",    o_alu_ready, 1'b1);
    chk1("b2b_ldrdy2",  o_ld_issue_ready, 1'b1);
    tick();
    chk32("b2b_rd2", 32'(o_rd), 32'd12);
    i_ld_rdata = 32'hD13; i_ld_rd = 5'd14; i_alu_rd = 5'd22; i_alu_data = 32'hA2;
    #1;
    chk1("b2b_rdy3", o_alu_ready, 1'b0);
    tick();
    chk32("b2b_rd3", 32'(o_rd), 32'd13);
    i_ld_rdata = 32'hD14; i_ld_issue = 1'b0;
    #1;
    chk1("b2b_rdy4", o_alu_ready, 1'b0);
    tick();
    chk32("b2b_rd4",   32'(o_rd), 32'd14);
    chk32("b2b_data4", o_data, 32'hD14);
    idle_inputs();
    tick();
    chk32("drain_rd1",   32'(o_rd), 32'd20);
    chk32("drain_data1", o_data, 32'hA0);
    chk1 ("drain_rdy",   o_alu_ready, 1'b1);
    tick();
    chk32("drain_rd2",   32'(o_rd), 32'd21);
    chk32("drain_data2", o_data, 32'hA1);
    tick();
    chk1("drain_done", o_write, 1'b0);

    // Destination x0 consumed without a write; rs=0 never forwards.
    i_alu_valid = 1'b1; i_alu_rd = 5'd0; i_alu_data = 32'hFFFF;
    tick();
    i_alu_valid = 1'b0;
    chk1("x0_write", o_write, 1'b0);
    tick();
    chk1("x0_write2", o_write, 1'b0);
    chk1("x0_fv",     o_fwd1_valid, 1'b0);
    chk1("x0_stall",  o_stall, 1'b0);

    // Two results for x9 queued: younger value forwards.
    i_ld_issue = 1'b1; i_ld_rd = 5'd15;
    tick();
    i_ld_rvalid = 1'b1; i_ld_rdata = 32'h15; i_ld_rd = 5'd16;
    i_alu_valid = 1'b1; i_alu_rd = 5'd9; i_alu_data = 32'h900;
    tick();
    i_ld_issue = 1'b0; i_ld_rdata = 32'h16; i_alu_data = 32'h901;
    tick();
    idle_inputs();
    i_dec_rs2 = 5'd9;
    #1;
    chk32("x9_rd16",    32'(o_rd), 32'd16);
    chk1 ("x9_full",    o_alu_ready, 1'b0);
    chk1 ("x9_stall",   o_stall, !FWD);
    chk1 ("x9_fv",      o_fwd2_valid, FWD);
    chk32("x9_fd",      o_fwd2_data, FWD ? 32'h901 : 32'h0);
    tick();
    chk32("x9_out_d",   o_data, 32'h900);
    chk32("x9_fd_fifo", o_fwd2_data, FWD ? 32'h901 : 32'h0);
    tick();
    chk32("x9_out_d2",  o_data, 32'h901);
    i_dec_rs2 = '0;

    // Load queue full, then reset mid-flight.
    i_ld_issue = 1'b1; i_ld_rd = 5'd17;
    tick();
    i_ld_rd = 5'd18;
    i_alu_valid = 1'b1; i_alu_rd = 5'd25; i_alu_data = 32'h2525;
    tick();
    i_ld_issue = 1'b0; i_alu_valid = 1'b0; i_dec_rd = 5'd18;
    #1;
    chk1 ("full_ldrdy",  o_ld_issue_ready, 1'b0);
    chk1 ("full_waw",    o_stall, 1'b1);
    chk32("full_rd25",   32'(o_rd), 32'd25);
    i_reset_n = 1'b0;
    #1;
    chk1 ("mid_write",   o_write, 1'b0);
    chk32("mid_rd",      32'(o_rd), 32'd0);
    chk32("mid_data",    o_data, 32'd0);
    chk1 ("mid_stall",   o_stall, 1'b0);
    idle_inputs();
    tick();
    i_reset_n = 1'b1;
    tick();
    chk1("post_ldrdy",  o_ld_issue_ready, 1'b1);
    chk1("post_alurdy", o_alu_ready, 1'b1);
    chk1("post_write",  o_write, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
